// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect input and decoder-side buffer outputs.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, 2-entry {pc, word} buffer, redirect with response drop.
//   state  | meaning
//   S_RUN  | normal fetch; responses are pushed into the buffer
//   S_DROP | stale request still pending after a redirect; its response is discarded
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    typedef enum logic {S_RUN, S_DROP} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic        outstanding_q;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_word [2];
    logic        head_q;
    logic [1:0]  count_q;

    logic [31:0] redirect_tgt;
    logic        valid;
    logic        req;
    logic        hold;
    logic        push;
    logic        pop;
    logic        tail;
    logic [1:0]  count_after_pop;

    assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
    assign tail         = head_q ^ count_q[0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (bus.redirect && hold) state_d = S_DROP;
            S_DROP:  if (bus.imem_ack)         state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // A new request is not started in a redirect cycle; the new stream begins next cycle.
    always_comb begin
        valid           = !rst && (count_q != 2'd0);
        count_after_pop = count_q - {1'b0, valid && bus.instr_ready};
        req             = !rst && (outstanding_q ||
                          (state_q == S_RUN && !bus.redirect && count_after_pop < 2'd2));
        hold            = req && !bus.imem_ack;
        push            = req && bus.imem_ack && state_q == S_RUN && !bus.redirect;
        pop             = valid && bus.instr_ready && !bus.redirect;
        bus.imem_req    = req;
        bus.imem_addr   = req ? pc_q : 32'h0;
        bus.instr_valid = valid;
        bus.instr       = valid ? fifo_word[head_q] : 32'h0;
        bus.instr_pc    = valid ? fifo_pc[head_q]   : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC_ALIGNED;
            tgt_q         <= 32'h0;
            outstanding_q <= 1'b0;
            head_q        <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            outstanding_q <= hold;

            if (bus.redirect) begin
                count_q <= 2'd0;
            end else begin
                if (pop) head_q <= ~head_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end

            if (push) begin
                fifo_pc[tail]   <= pc_q;
                fifo_word[tail] <= bus.imem_rdata;
            end

            // pc_q stays on the stale address during DROP so imem_addr holds; tgt_q keeps the latest target.
            case (state_q)
                S_RUN: begin
                    if (bus.redirect) begin
                        if (hold) tgt_q <= redirect_tgt;
                        else      pc_q  <= redirect_tgt;
                    end else if (push) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_DROP: begin
                    if (bus.imem_ack)     pc_q  <= bus.redirect ? redirect_tgt : tgt_q;
                    else if (bus.redirect) tgt_q <= redirect_tgt;
                end
                default: pc_q <= pc_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected fetch stream queued per scenario, compared as the decoder consumes it.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if bus_if ();
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ack_mode: 0 = no ack, 1 = ack if requested, 2 = ack forced high
    task automatic tick(input logic rs, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input int ack_mode);
        @(negedge clk);
        rst                = rs;
        bus_if.instr_ready = rdy;
        bus_if.redirect    = rd;
        bus_if.redirect_pc = rpc;
        #1;
        bus_if.imem_ack   = (ack_mode == 2) || (ack_mode == 1 && bus_if.imem_req);
        bus_if.imem_rdata = mem_word(bus_if.imem_addr);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        exp_q.delete();
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1);
        total++;
        if (bus_if.imem_req !== 1'b0 || bus_if.instr_valid !== 1'b0)
            $display("FAIL reset_ctl: req=%b valid=%b expected 0 0", bus_if.imem_req, bus_if.instr_valid);
        else passed++;
        total++;
        if (bus_if.imem_addr !== 32'h0 || bus_if.instr !== 32'h0 || bus_if.instr_pc !== 32'h0)
            $display("FAIL reset_data: addr=%h instr=%h pc=%h expected zeros",
                     bus_if.imem_addr, bus_if.instr, bus_if.instr_pc);
        else passed++;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 0);
        total++;
        if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h0)
            $display("FAIL reset_release: req=%b addr=%h expected 1 00000000", bus_if.imem_req, bus_if.imem_addr);
        else passed++;
    endtask

    task automatic test_stream();
        int n = 0;
        int last = 0;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
            if (bus_if.instr_valid && bus_if.instr_ready) begin
                total++;
                if ((n == 0 && c != 1) || (n != 0 && c != last + 1))
                    $display("FAIL stream_timing: pop %0d at cycle %0d, expected cycle %0d", n, c, (n == 0) ? 1 : last + 1);
                else passed++;
                e = exp_q.pop_front();
                total++;
                if (bus_if.instr_pc !== e || bus_if.instr !== mem_word(e))
                    $display("FAIL stream_pop: pc=%h instr=%h expected %h %h", bus_if.instr_pc, bus_if.instr, e, mem_word(e));
                else passed++;
                last = c;
                n++;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL stream_done: %0d left, expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 10; c++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 32'h0 || bus_if.imem_req !== 1'b0)
            $display("FAIL bp_full: valid=%b pc=%h req=%b expected 1 00000000 0",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.imem_req);
        else passed++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        for (int c = 0; c < 15 && exp_q.size() != 0; c++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
            if (c == 0) begin
                total++;
                if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h8)
                    $display("FAIL bp_resume: req=%b addr=%h expected 1 00000008", bus_if.imem_req, bus_if.imem_addr);
                else passed++;
            end
            if (bus_if.instr_valid && bus_if.instr_ready) begin
                e = exp_q.pop_front();
                total++;
                if (bus_if.instr_pc !== e || bus_if.instr !== mem_word(e))
                    $display("FAIL bp_pop: pc=%h instr=%h expected %h %h", bus_if.instr_pc, bus_if.instr, e, mem_word(e));
                else passed++;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL bp_done: %0d left, expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_ack_delay();
        do_reset();
        exp_q.push_back(32'h0);
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, (c == 3) ? 1 : 0);
            total++;
            if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h0 || bus_if.instr_valid !== 1'b0)
                $display("FAIL delay_hold: cycle %0d req=%b addr=%h valid=%b expected 1 00000000 0",
                         c, bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid);
            else passed++;
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
        total++;
        if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h4)
            $display("FAIL delay_next: req=%b addr=%h expected 1 00000004", bus_if.imem_req, bus_if.imem_addr);
        else passed++;
        total++;
        if (!(bus_if.instr_valid && bus_if.instr_ready)) begin
            $display("FAIL delay_valid: valid=%b expected 1", bus_if.instr_valid);
        end else begin
            e = exp_q.pop_front();
            if (bus_if.instr_pc !== e || bus_if.instr !== mem_word(e))
                $display("FAIL delay_pop: pc=%h instr=%h expected %h %h", bus_if.instr_pc, bus_if.instr, e, mem_word(e));
            else passed++;
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h100);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            case (c)
                0:       tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
                1:       tick(1'b0, 1'b0, 1'b1, 32'h0000_0103, 0);
                2:       tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
                3:       tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
                4:       tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
                default: tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
            endcase
            if (c >= 1 && c <= 3) begin
                total++;
                if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h8)
                    $display("FAIL drop_hold: cycle %0d req=%b addr=%h expected 1 00000008", c, bus_if.imem_req, bus_if.imem_addr);
                else passed++;
            end
            if (c == 2 || c == 4) begin
                total++;
                if (bus_if.instr_valid !== 1'b0)
                    $display("FAIL drop_flush: cycle %0d valid=%b expected 0", c, bus_if.instr_valid);
                else passed++;
            end
            if (c == 4) begin
                total++;
                if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h100)
                    $display("FAIL drop_newpc: req=%b addr=%h expected 1 00000100", bus_if.imem_req, bus_if.imem_addr);
                else passed++;
            end
            if (bus_if.instr_valid && bus_if.instr_ready) begin
                e = exp_q.pop_front();
                total++;
                if (bus_if.instr_pc !== e || bus_if.instr !== mem_word(e))
                    $display("FAIL drop_pop: pc=%h instr=%h expected %h %h", bus_if.instr_pc, bus_if.instr, e, mem_word(e));
                else passed++;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL drop_done: %0d left, expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_wrap_latest();
        do_reset();
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0040, 0);
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 0);
        total++;
        if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h0)
            $display("FAIL wrap_drop_hold: req=%b addr=%h expected 1 00000000", bus_if.imem_req, bus_if.imem_addr);
        else passed++;
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
        for (int c = 0; c < 15 && exp_q.size() != 0; c++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
            if (c == 0) begin
                total++;
                if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'hFFFF_FFF8)
                    $display("FAIL wrap_target: req=%b addr=%h expected 1 fffffff8", bus_if.imem_req, bus_if.imem_addr);
                else passed++;
            end
            if (bus_if.instr_valid && bus_if.instr_ready) begin
                e = exp_q.pop_front();
                total++;
                if (bus_if.instr_pc !== e || bus_if.instr !== mem_word(e))
                    $display("FAIL wrap_pop: pc=%h instr=%h expected %h %h", bus_if.instr_pc, bus_if.instr, e, mem_word(e));
                else passed++;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL wrap_done: %0d left, expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_midack();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 2);
        total++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.imem_req !== 1'b0 || bus_if.imem_addr !== 32'h0)
            $display("FAIL rstack_during: valid=%b req=%b addr=%h expected 0 0 00000000",
                     bus_if.instr_valid, bus_if.imem_req, bus_if.imem_addr);
        else passed++;
        tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
        total++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 32'h0)
            $display("FAIL rstack_after: valid=%b req=%b addr=%h expected 0 1 00000000",
                     bus_if.instr_valid, bus_if.imem_req, bus_if.imem_addr);
        else passed++;
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.imem_ack    = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        bus_if.instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_ack_delay();
        test_redirect_drop();
        test_wrap_latest();
        test_reset_midack();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be treated as 0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-006 imem_ack  input  1  memory accepted the request and imem_rdata is valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect  input  1  control-flow change from the execute stage (branch, jump, jr).
REQ-009 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-010 instr_valid  output  1  instr/instr_pc hold a valid instruction for the decoder.
REQ-011 instr_ready  input  1  decoder accepts the head instruction this cycle.
REQ-012 instr  output  32  instruction word at the buffer head.
REQ-013 instr_pc  output  32  address of instr (decoder uses it for link value pc+8 and branch base).

Function
REQ-014 Internal state SHALL be: fetch PC register, 2-entry FIFO of {pc, word}, outstanding flag, and FSM with states RUN and DROP.
REQ-015 Memory handshake: once imem_req=1, imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1; at most one request SHALL be outstanding; imem_ack with imem_req=0 SHALL be ignored.
REQ-016 In RUN, a new request SHALL be raised only when fifo_count + outstanding < 2, counting a pop in the same cycle (occupancy never exceeds 2).
REQ-017 Request issue is registered: ack in cycle N SHALL push {imem_addr, imem_rdata} into the FIFO, make instr_valid=1 in cycle N+1 (if FIFO was empty), and allow the next request (address +4) in cycle N+1.
REQ-018 PC increment SHALL be +4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 instr_valid SHALL equal (fifo_count != 0); instr and instr_pc SHALL reflect the head entry; a pop SHALL occur when instr_valid && instr_ready.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged and keep order.
REQ-021 A redirect in cycle N SHALL flush the FIFO (instr_valid=0 in N+1), discard any imem_rdata acked in cycle N, and set fetch PC to {redirect_pc[31:2], 2'b00}; redirect SHALL take priority over push and pop.
REQ-022 Redirect with no request outstanding after cycle N: first request to the new PC SHALL be raised in cycle N+1.
REQ-023 Redirect while a request is pending and not acked in cycle N: FSM SHALL enter DROP, keep imem_req/imem_addr stable for the old address, discard its response on ack, then return to RUN and request the new PC the cycle after the ack.
REQ-024 A further redirect while in DROP SHALL replace the target PC (latest wins) without leaving DROP early.
REQ-025 instr_ready while instr_valid=0 SHALL have no effect.

Reset
REQ-026 While rst=1: imem_req=0, instr_valid=0, FIFO empty, outstanding=0, FSM=RUN, fetch PC=RESET_PC; imem_addr, instr, instr_pc SHALL read 0.
REQ-027 rst asserted mid-transaction SHALL abandon any pending request and drop any response acked in the reset cycle.
REQ-028 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-029 Reset, ack every cycle, instr_ready=1 -> instr_pc sequence 0,4,8,12 on consecutive valid cycles, instr matches memory image.
REQ-030 instr_ready=0 for 10 cycles, ack every cycle -> exactly 2 entries buffered (pc 0,4), imem_req=0 afterward; ready=1 -> 0,4 drained in order, fetching resumes at 8.
REQ-031 Ack delayed 3 cycles -> imem_req/imem_addr stable across the wait; no second request issued.
REQ-032 Redirect to 32'h0000_0103 while request for 8 pending, ack 2 cycles later -> word for 8 never presented; next request addr 32'h0000_0100; FIFO flushed.
REQ-033 Redirect to 32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-034 rst asserted in cycle a request is acked -> no instr_valid; after release imem_addr=RESET_PC.
